// File: rtl/clk_cfg_pkg.sv
// Shared definitions for the clock-select sequencer: cfg word layout,
// sequencer state codes and the divider / ROSC select encodings.
package clk_cfg_pkg;

  localparam int CFG_W    = 7;
  localparam int DIV_LSB  = 0;
  localparam int ROSC_LSB = 2;
  localparam int MUX0_BIT = 4;
  localparam int MUX1_BIT = 5;
  localparam int MUX2_BIT = 6;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_PARK   = 3'd1;
  localparam state_t ST_SRC    = 3'd2;
  localparam state_t ST_MUX1   = 3'd3;
  localparam state_t ST_DIV    = 3'd4;
  localparam state_t ST_UNPARK = 3'd5;
  localparam state_t ST_DONE   = 3'd6;

  typedef enum logic [1:0] {
    CLK_DIV_1 = 2'b00,
    CLK_DIV_2 = 2'b01,
    CLK_DIV_4 = 2'b10,
    CLK_DIV_8 = 2'b11
  } clk_div_e;

  typedef enum logic [1:0] {
    ROSC_128 = 2'b00,
    ROSC_64  = 2'b01,
    ROSC_32  = 2'b10,
    ROSC_16  = 2'b11
  } rosc_sel_e;

endpackage

// File: rtl/settle_timer.sv
// Saturating settle counter: clr restarts it at zero, done is high once
// SETTLE_CYC-1 is reached and stays high until the next clr.
module settle_timer #(
  parameter int SETTLE_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic done
);

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt == LAST);

endmodule

// File: rtl/clk_cfg_seq.sv
// Clock-select sequencer: applies a written configuration in the order
// park, source, mux1, divider, unpark, and falls back to ROSC on xclk failure.
module clk_cfg_seq
  import clk_cfg_pkg::*;
#(
  parameter int           SETTLE_CYC = 16,
  parameter logic [6:0]   RST_CFG    = 7'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_wr,
  input  logic [6:0] cfg_wdata,
  input  logic       xclk_fail,
  input  logic       fail_clr,
  output logic       cfg_ack,
  output logic       busy,
  output logic       xclk_failed,
  output logic [6:0] cfg_cur,
  output logic       sel_mux0,
  output logic       sel_mux1,
  output logic       sel_mux2,
  output logic [1:0] sel_rosc,
  output logic [1:0] clk_div,
  output logic [2:0] dbg_state
);

  // Handshake: cfg_wr is a single-cycle strobe honoured only while busy=0;
  // each accepted write yields exactly one cfg_ack pulse as busy falls.

  state_t           state, state_nxt;
  logic [CFG_W-1:0] target;
  logic             fail_hit;
  logic             entering;
  logic             tmr_done;

  assign fail_hit = xclk_fail & cfg_cur[MUX1_BIT];
  assign entering = (state_nxt != state);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (cfg_wr)   state_nxt = ST_PARK;
      ST_PARK:   if (tmr_done) state_nxt = ST_SRC;
      ST_SRC:    if (tmr_done) state_nxt = ST_MUX1;
      ST_MUX1:   if (tmr_done) state_nxt = ST_DIV;
      ST_DIV:    if (tmr_done) state_nxt = ST_UNPARK;
      ST_UNPARK: if (tmr_done) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    // A failure drops any pending write in IDLE and aborts a running sequence.
    if (fail_hit) begin
      state_nxt = (state == ST_IDLE) ? ST_IDLE : ST_DONE;
    end
  end

  settle_timer #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_settle (
    .clk  (clk),
    .rst  (rst),
    .clr  (entering),
    .done (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      cfg_ack     <= 1'b0;
      xclk_failed <= 1'b0;
      target      <= RST_CFG;
      cfg_cur     <= RST_CFG;
    end else begin
      state       <= state_nxt;
      busy        <= (state_nxt != ST_IDLE);
      cfg_ack     <= (state == ST_DONE) && (state_nxt == ST_IDLE);
      xclk_failed <= fail_hit | (xclk_failed & ~fail_clr);
      if ((state == ST_IDLE) && (state_nxt == ST_PARK)) begin
        target <= cfg_wdata;
      end
      if (fail_hit) begin
        cfg_cur[MUX0_BIT] <= 1'b0;
        cfg_cur[MUX1_BIT] <= 1'b0;
      end else if (entering) begin
        case (state_nxt)
          ST_PARK: cfg_cur[MUX0_BIT] <= 1'b0;
          ST_SRC: begin
            cfg_cur[ROSC_LSB +: 2] <= target[ROSC_LSB +: 2];
            cfg_cur[MUX2_BIT]      <= target[MUX2_BIT];
          end
          ST_MUX1: cfg_cur[MUX1_BIT]     <= target[MUX1_BIT];
          ST_DIV:  cfg_cur[DIV_LSB +: 2] <= target[DIV_LSB +: 2];
          // Stay parked on ROSC if the external clock is known bad.
          ST_UNPARK: cfg_cur[MUX0_BIT] <= target[MUX0_BIT] &
                                          ~(target[MUX1_BIT] & xclk_failed);
          default: ;
        endcase
      end
    end
  end

  assign sel_mux0  = cfg_cur[MUX0_BIT];
  assign sel_mux1  = cfg_cur[MUX1_BIT];
  assign sel_mux2  = cfg_cur[MUX2_BIT];
  assign sel_rosc  = cfg_cur[ROSC_LSB +: 2];
  assign clk_div   = cfg_cur[DIV_LSB +: 2];
  assign dbg_state = state;

endmodule

// File: tb/tb_clk_cfg_seq.sv
// Bench for clk_cfg_seq: directed steps plus random writes and failure
// injections, checked against a timeline model of the select sequence.
module tb_clk_cfg_seq;

  localparam int         SETTLE  = 16;
  localparam logic [6:0] RST_VAL = 7'h00;

  logic       clk = 1'b0;
  logic       rst, cfg_wr, xclk_fail, fail_clr;
  logic [6:0] cfg_wdata;
  logic       cfg_ack, busy, xclk_failed;
  logic [6:0] cfg_cur;
  logic       sel_mux0, sel_mux1, sel_mux2;
  logic [1:0] sel_rosc, clk_div;
  logic [2:0] dbg_state;

  int         total = 0;
  int         bad   = 0;
  logic [6:0] model_cfg;
  logic       model_failed;

  always #5 clk = ~clk;

  clk_cfg_seq #(
    .SETTLE_CYC (SETTLE),
    .RST_CFG    (RST_VAL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_wr      (cfg_wr),
    .cfg_wdata   (cfg_wdata),
    .xclk_fail   (xclk_fail),
    .fail_clr    (fail_clr),
    .cfg_ack     (cfg_ack),
    .busy        (busy),
    .xclk_failed (xclk_failed),
    .cfg_cur     (cfg_cur),
    .sel_mux0    (sel_mux0),
    .sel_mux1    (sel_mux1),
    .sel_mux2    (sel_mux2),
    .sel_rosc    (sel_rosc),
    .clk_div     (clk_div),
    .dbg_state   (dbg_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input string name, input logic [6:0] got,
                     input logic [6:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s.%s got=%h exp=%h", tag, name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [6:0] e_cfg, input logic e_busy,
                           input logic e_ack, input logic e_failed);
    chk(tag, "cfg_cur", cfg_cur, e_cfg);
    chk(tag, "selects", {sel_mux2, sel_mux1, sel_mux0, sel_rosc, clk_div}, e_cfg);
    chk(tag, "busy", {6'b0, busy}, {6'b0, e_busy});
    chk(tag, "ack", {6'b0, cfg_ack}, {6'b0, e_ack});
    chk(tag, "failed", {6'b0, xclk_failed}, {6'b0, e_failed});
  endtask

  // Config seen k cycles after the write cycle: each field group switches
  // at a fixed offset, one settle window after the previous one.
  function automatic logic [6:0] cfg_at(input int k, input logic [6:0] start,
                                        input logic [6:0] tgt, input logic failed);
    logic [6:0] c;
    c = start;
    if (k >= 1) c[4] = 1'b0;
    if (k >= 1 + SETTLE) begin
      c[3:2] = tgt[3:2];
      c[6]   = tgt[6];
    end
    if (k >= 1 + 2 * SETTLE) c[5] = tgt[5];
    if (k >= 1 + 3 * SETTLE) c[1:0] = tgt[1:0];
    if (k >= 1 + 4 * SETTLE) c[4] = (tgt[5] && tgt[4] && failed) ? 1'b0 : tgt[4];
    return c;
  endfunction

  // One write, checked every cycle. fail_at/wr2_at/rst_at = cycle offset to
  // inject xclk_fail, a second write, or reset (0 = none).
  task automatic run_seq(input string tag, input logic [6:0] wd, input int fail_at,
                         input int wr2_at, input int rst_at);
    logic [6:0] start, exp_c, abort_c;
    logic       held_failed, aborted;
    int         abort_k;
    int         ack_k;
    start       = model_cfg;
    held_failed = model_failed;
    aborted     = 1'b0;
    abort_k     = 0;
    abort_c     = '0;
    exp_c       = start;
    ack_k       = 2 + 5 * SETTLE;
    cfg_wdata   = wd;
    cfg_wr      = 1'b1;
    for (int k = 1; k <= ack_k + 8; k++) begin
      step();
      cfg_wr    = 1'b0;
      xclk_fail = 1'b0;
      rst       = 1'b0;
      if (rst_at != 0 && k == rst_at + 1) begin
        model_cfg    = RST_VAL;
        model_failed = 1'b0;
        check_all(tag, RST_VAL, 1'b0, 1'b0, 1'b0);
        return;
      end
      if (aborted) begin
        exp_c = abort_c;
        check_all(tag, exp_c, k < abort_k + 2, k == abort_k + 2, model_failed);
        if (k == abort_k + 2) break;
      end else begin
        exp_c = cfg_at(k, start, wd, held_failed);
        check_all(tag, exp_c, k < ack_k, k == ack_k, model_failed);
        if (k == ack_k) break;
      end
      if (k == wr2_at) begin
        cfg_wr    = 1'b1;
        cfg_wdata = ~wd;
      end
      if (k == rst_at) rst = 1'b1;
      if (!aborted && k == fail_at) begin
        xclk_fail = 1'b1;
        if (exp_c[5]) begin
          aborted      = 1'b1;
          abort_k      = k;
          abort_c      = exp_c & 7'b100_1111;
          model_failed = 1'b1;
        end
      end
    end
    model_cfg = exp_c;
    step();
    check_all({tag, ".idle"}, model_cfg, 1'b0, 1'b0, model_failed);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_wr = 1'b0; cfg_wdata = '0; xclk_fail = 1'b0; fail_clr = 1'b0;
    model_cfg = RST_VAL; model_failed = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_all("reset", RST_VAL, 1'b0, 1'b0, 1'b0);

    // Full write of 0x36 with a second write at T+20 that must be ignored.
    run_seq("wr36", 7'h36, 0, 20, 0);

    // Failure in IDLE while mux1 selected.
    xclk_fail = 1'b1;
    step();
    xclk_fail = 1'b0;
    model_cfg = 7'h06; model_failed = 1'b1;
    check_all("idle_fail", model_cfg, 1'b0, 1'b0, 1'b1);

    // With the flag set, mux0 stays parked after the sequence.
    run_seq("held", 7'h36, 0, 0, 0);
    chk("held", "final", cfg_cur, 7'h26);

    // Set wins over clear.
    fail_clr = 1'b1; xclk_fail = 1'b1;
    step();
    fail_clr = 1'b0; xclk_fail = 1'b0;
    model_cfg = 7'h06; model_failed = 1'b1;
    check_all("set_wins", model_cfg, 1'b0, 1'b0, 1'b1);

    fail_clr = 1'b1;
    step();
    fail_clr = 1'b0;
    model_failed = 1'b0;
    check_all("clr", model_cfg, 1'b0, 1'b0, 1'b0);

    // mux1=0, so the failure indication is ignored.
    xclk_fail = 1'b1;
    step();
    xclk_fail = 1'b0;
    check_all("fail_ignored", model_cfg, 1'b0, 1'b0, 1'b0);

    run_seq("wr36b", 7'h36, 0, 0, 0);

    // Write and failure together in IDLE: failure handled, write dropped.
    cfg_wr = 1'b1; cfg_wdata = 7'h11; xclk_fail = 1'b1;
    step();
    cfg_wr = 1'b0; xclk_fail = 1'b0;
    model_cfg = 7'h06; model_failed = 1'b1;
    check_all("wr_fail", model_cfg, 1'b0, 1'b0, 1'b1);
    step();
    check_all("wr_fail2", model_cfg, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 10; i++) begin
      logic [6:0] wd;
      int         fa;
      if ($urandom_range(0, 1) == 1) begin
        fail_clr = 1'b1;
        step();
        fail_clr = 1'b0;
        model_failed = 1'b0;
        check_all("rand_clr", model_cfg, 1'b0, 1'b0, 1'b0);
      end
      wd = 7'($urandom_range(0, 127));
      fa = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 80) : 0;
      run_seq("rand", wd, fa, 0, 0);
    end

    // Reset while in the DIV window: no ack, everything back to reset config.
    run_seq("rst_div", 7'h7f, 0, 0, 3 * SETTLE + 7);
    for (int i = 0; i < 20; i++) begin
      step();
      check_all("post_rst", RST_VAL, 1'b0, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
